rat_arf_superscalar: RTL

//  Multi-port register alias table plus architectural register file. It is the parametrised

---
 rtl/rat_arf_superscalar_pkg.sv | 37 +++
 rtl/rat_arf_superscalar_src_lookup.sv | 79 +++++++
 rtl/rat_arf_superscalar.sv | 117 +++++++++++
 3 files changed

// File: rtl/rat_arf_superscalar_pkg.sv
// -----------------------------------------------------------------------------
// rat_arf_superscalar_pkg
// Shared types for the multi-port register alias table / architectural
// register file. The flattened top-level ports are packed into these structs
// at the module boundary.
//   rat_entry_t  : per-register rename state {busy, tag}
//   rat_disp_t   : one dispatch slot {valid, rd_addr, rob_idx}
//   rat_commit_t : one commit lane {valid, rd_addr, rob_idx, data}
// The struct field widths follow the RAT_* localparams below. The top-level
// parameters default to these values and must be kept equal to them.
// -----------------------------------------------------------------------------
package rat_arf_superscalar_pkg;

    localparam int unsigned RAT_XLEN      = 32;
    localparam int unsigned RAT_NUM_REGS  = 32;
    localparam int unsigned RAT_ROB_W     = 5;
    localparam int unsigned RAT_AW        = $clog2(RAT_NUM_REGS);

    typedef struct packed {
        logic                 busy;
        logic [RAT_ROB_W-1:0] tag;
    } rat_entry_t;

    typedef struct packed {
        logic                 valid;
        logic [RAT_AW-1:0]    rd_addr;
        logic [RAT_ROB_W-1:0] rob_idx;
    } rat_disp_t;

    typedef struct packed {
        logic                 valid;
        logic [RAT_AW-1:0]    rd_addr;
        logic [RAT_ROB_W-1:0] rob_idx;
        logic [RAT_XLEN-1:0]  data;
    } rat_commit_t;

endpackage

// File: rtl/rat_arf_superscalar_src_lookup.sv
// -----------------------------------------------------------------------------
// rat_arf_superscalar_src_lookup
// Zero-cycle lookup for a single source operand belonging to dispatch slot
// SLOT. Priority: intra-group producer in an older slot, then the rename
// table (optionally bypassing a same-cycle matching commit), then the ARF.
// Optional feature macro: RAT_COMMIT_BYPASS_EN (adds the i_commit port).
// Ports:
//   i_src_addr : architectural source register
//   i_disp     : this cycle's dispatch slots (slot 0 oldest)
//   i_commit   : this cycle's commit lanes (bypass build only)
//   i_rat      : rename table {busy, tag} per register
//   i_arf      : committed register values
//   o_ready    : 1 = o_data valid
//   o_data     : operand value when ready, else 0
//   o_rob_idx  : producer tag when not ready, else 0
// -----------------------------------------------------------------------------
module rat_arf_superscalar_src_lookup
    import rat_arf_superscalar_pkg::*;
#(
    parameter int          SLOT           = 0,
    parameter int unsigned XLEN           = RAT_XLEN,
    parameter int unsigned NUM_ARCH_REGS  = RAT_NUM_REGS,
    parameter int unsigned ROB_IDX_WIDTH  = RAT_ROB_W,
    parameter int unsigned DISPATCH_WIDTH = 2,
`ifdef RAT_COMMIT_BYPASS_EN
    parameter int unsigned COMMIT_WIDTH   = 2,
`endif
    localparam int unsigned AW            = $clog2(NUM_ARCH_REGS)
) (
    input  logic [AW-1:0]            i_src_addr,
    input  rat_disp_t                i_disp   [DISPATCH_WIDTH],
`ifdef RAT_COMMIT_BYPASS_EN
    input  rat_commit_t              i_commit [COMMIT_WIDTH],
`endif
    input  rat_entry_t               i_rat    [NUM_ARCH_REGS],
    input  logic [XLEN-1:0]          i_arf    [NUM_ARCH_REGS],
    output logic                     o_ready,
    output logic [XLEN-1:0]          o_data,
    output logic [ROB_IDX_WIDTH-1:0] o_rob_idx
);

    rat_entry_t w_entry;

    always_comb begin
        w_entry   = i_rat[i_src_addr];
        o_ready   = 1'b1;
        o_data    = i_arf[i_src_addr];
        o_rob_idx = '0;
        if (i_src_addr == '0) begin
            o_data = '0;
        end else begin
            if (w_entry.busy) begin
                o_ready   = 1'b0;
                o_data    = '0;
                o_rob_idx = w_entry.tag;
`ifdef RAT_COMMIT_BYPASS_EN
                // Ascending scan: the youngest matching lane wins.
                for (int c = 0; c < int'(COMMIT_WIDTH); c++) begin
                    if (i_commit[c].valid && i_commit[c].rd_addr == i_src_addr &&
                        i_commit[c].rob_idx == w_entry.tag) begin
                        o_ready   = 1'b1;
                        o_data    = i_commit[c].data;
                        o_rob_idx = '0;
                    end
                end
`endif
            end
            // Only older slots can feed this one; the last match is the youngest.
            for (int i = 0; i < int'(DISPATCH_WIDTH); i++) begin
                if (i < SLOT && i_disp[i].valid && i_disp[i].rd_addr == i_src_addr) begin
                    o_ready   = 1'b0;
                    o_data    = '0;
                    o_rob_idx = i_disp[i].rob_idx;
                end
            end
        end
    end

endmodule

// File: rtl/rat_arf_superscalar.sv
// -----------------------------------------------------------------------------
// rat_arf_superscalar
// Multi-port register alias table plus architectural register file. Renames
// each dispatching rd to its ROB tag, answers source lookups combinationally,
// takes in-order commit writes and drops all speculative mappings on flush.
// Optional feature macro: RAT_COMMIT_BYPASS_EN (same-cycle commit bypass).
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   disp_valid/rd_addr/rob_idx : per-slot rename requests (slot 0 oldest)
//   src_addr                 : sources, 2k = rs1 / 2k+1 = rs2 of slot k
//   src_ready/data/rob_idx   : lookup results
//   commit_valid/rd_addr/rob_idx/data : per-lane retirement (lane 0 oldest)
//   flush                    : clear every busy bit
// -----------------------------------------------------------------------------
module rat_arf_superscalar
    import rat_arf_superscalar_pkg::*;
#(
    parameter int unsigned XLEN           = RAT_XLEN,
    parameter int unsigned NUM_ARCH_REGS  = RAT_NUM_REGS,
    parameter int unsigned ROB_IDX_WIDTH  = RAT_ROB_W,
    parameter int unsigned DISPATCH_WIDTH = 2,
    parameter int unsigned COMMIT_WIDTH   = 2,
    localparam int unsigned AW            = $clog2(NUM_ARCH_REGS),
    localparam int unsigned NSRC          = 2 * DISPATCH_WIDTH
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [DISPATCH_WIDTH-1:0]                    disp_valid,
    input  logic [DISPATCH_WIDTH-1:0][AW-1:0]            disp_rd_addr,
    input  logic [DISPATCH_WIDTH-1:0][ROB_IDX_WIDTH-1:0] disp_rob_idx,
    input  logic [NSRC-1:0][AW-1:0]                      src_addr,
    output logic [NSRC-1:0]                              src_ready,
    output logic [NSRC-1:0][XLEN-1:0]                    src_data,
    output logic [NSRC-1:0][ROB_IDX_WIDTH-1:0]           src_rob_idx,
    input  logic [COMMIT_WIDTH-1:0]                      commit_valid,
    input  logic [COMMIT_WIDTH-1:0][AW-1:0]              commit_rd_addr,
    input  logic [COMMIT_WIDTH-1:0][ROB_IDX_WIDTH-1:0]   commit_rob_idx,
    input  logic [COMMIT_WIDTH-1:0][XLEN-1:0]            commit_data,
    input  logic                                         flush
);

    rat_disp_t       w_disp   [DISPATCH_WIDTH];
    rat_commit_t     w_commit [COMMIT_WIDTH];
    rat_entry_t      r_rat    [NUM_ARCH_REGS];
    logic [XLEN-1:0] r_arf    [NUM_ARCH_REGS];

    for (genvar k = 0; k < int'(DISPATCH_WIDTH); k++) begin : g_disp
        assign w_disp[k] = '{valid: disp_valid[k], rd_addr: disp_rd_addr[k],
                             rob_idx: disp_rob_idx[k]};
    end

    for (genvar c = 0; c < int'(COMMIT_WIDTH); c++) begin : g_commit
        assign w_commit[c] = '{valid: commit_valid[c], rd_addr: commit_rd_addr[c],
                               rob_idx: commit_rob_idx[c], data: commit_data[c]};
    end

    for (genvar s = 0; s < int'(NSRC); s++) begin : g_src
        rat_arf_superscalar_src_lookup #(
            .SLOT           (s / 2),
            .XLEN           (XLEN),
            .NUM_ARCH_REGS  (NUM_ARCH_REGS),
            .ROB_IDX_WIDTH  (ROB_IDX_WIDTH),
`ifdef RAT_COMMIT_BYPASS_EN
            .COMMIT_WIDTH   (COMMIT_WIDTH),
`endif
            .DISPATCH_WIDTH (DISPATCH_WIDTH)
        ) u_lookup (
            .i_src_addr (src_addr[s]),
            .i_disp     (w_disp),
`ifdef RAT_COMMIT_BYPASS_EN
            .i_commit   (w_commit),
`endif
            .i_rat      (r_rat),
            .i_arf      (r_arf),
            .o_ready    (src_ready[s]),
            .o_data     (src_data[s]),
            .o_rob_idx  (src_rob_idx[s])
        );
    end

    // Later loop iterations override earlier ones, which gives: higher lane
    // wins the ARF write, and any dispatch beats a same-cycle commit clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < int'(NUM_ARCH_REGS); r++) begin
                r_arf[r] <= '0;
                r_rat[r] <= '0;
            end
        end else begin
            for (int c = 0; c < int'(COMMIT_WIDTH); c++) begin
                if (w_commit[c].valid && w_commit[c].rd_addr != '0) begin
                    r_arf[w_commit[c].rd_addr] <= w_commit[c].data;
                end
            end
            if (flush) begin
                for (int r = 0; r < int'(NUM_ARCH_REGS); r++) begin
                    r_rat[r].busy <= 1'b0;
                end
            end else begin
                for (int c = 0; c < int'(COMMIT_WIDTH); c++) begin
                    // A stale commit (older tag) must not drop a newer mapping.
                    if (w_commit[c].valid && w_commit[c].rd_addr != '0 &&
                        r_rat[w_commit[c].rd_addr].tag == w_commit[c].rob_idx) begin
                        r_rat[w_commit[c].rd_addr].busy <= 1'b0;
                    end
                end
                for (int k = 0; k < int'(DISPATCH_WIDTH); k++) begin
                    if (w_disp[k].valid && w_disp[k].rd_addr != '0) begin
                        r_rat[w_disp[k].rd_addr].busy <= 1'b1;
                        r_rat[w_disp[k].rd_addr].tag  <= w_disp[k].rob_idx;
                    end
                end
            end
        end
    end

endmodule
